// File: rtl/split_scheduler.sv
// Split-constraint scheduler: latches one candidate assignment, walks the split
// blocks one at a time through a shared x mux, and reports the first failing
// split (or an all-pass) through a ready/valid result handshake.
module split_scheduler #(
  parameter int NUM_SPLITS = 8,
  parameter int CAND_W     = 64,
  parameter int EVAL_LAT   = 1,
  localparam int SEL_W     = (NUM_SPLITS > 1) ? $clog2(NUM_SPLITS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cand_valid,
  output logic              cand_ready,
  input  logic [CAND_W-1:0] cand_data,
  output logic [CAND_W-1:0] eval_vec,
  output logic [SEL_W-1:0]  split_sel,
  input  logic              split_x,
  input  logic              abort,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_pass,
  output logic [SEL_W-1:0]  res_fail_idx,
  output logic              busy,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt
);

  // Wait counter only has to hold EVAL_LAT-1; keep at least one bit.
  localparam int WAIT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(EVAL_LAT - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SPLITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t              state_p0,    state_nxt;
  logic [CAND_W-1:0]   vec_p0,      vec_nxt;
  logic [SEL_W-1:0]    sel_p0,      sel_nxt;
  logic [WAIT_W-1:0]   wait_p0,     wait_nxt;
  logic                pass_p0,     pass_nxt;
  logic [SEL_W-1:0]    fail_idx_p0, fail_idx_nxt;
  logic [15:0]         pass_cnt_p0, pass_cnt_nxt;
  logic [15:0]         fail_cnt_p0, fail_cnt_nxt;

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and datapath update; abort outranks any sample taken in the same cycle.
  always_comb begin
    state_nxt    = state_p0;
    vec_nxt      = vec_p0;
    sel_nxt      = sel_p0;
    wait_nxt     = wait_p0;
    pass_nxt     = pass_p0;
    fail_idx_nxt = fail_idx_p0;
    pass_cnt_nxt = pass_cnt_p0;
    fail_cnt_nxt = fail_cnt_p0;

    case (state_p0)
      ST_IDLE: begin
        if (cand_valid) begin
          vec_nxt   = cand_data;
          sel_nxt   = '0;
          wait_nxt  = WAIT_INIT;
          state_nxt = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (abort) begin
          // Drop the evaluation silently: no result, no counter movement.
          state_nxt = ST_IDLE;
        end else if (wait_p0 != '0) begin
          // Split outputs are still settling; x is not looked at yet.
          wait_nxt = wait_p0 - WAIT_W'(1);
        end else if (!split_x) begin
          // First unsatisfied split ends the walk early.
          pass_nxt     = 1'b0;
          fail_idx_nxt = sel_p0;
          fail_cnt_nxt = sat_inc(fail_cnt_p0);
          state_nxt    = ST_RESULT;
        end else if (sel_p0 == SEL_LAST) begin
          pass_nxt     = 1'b1;
          fail_idx_nxt = '0;
          pass_cnt_nxt = sat_inc(pass_cnt_p0);
          state_nxt    = ST_RESULT;
        end else begin
          sel_nxt  = sel_p0 + SEL_W'(1);
          wait_nxt = WAIT_INIT;
        end
      end

      ST_RESULT: begin
        // Return to IDLE only; acceptance waits for the following cycle.
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= ST_IDLE;
      vec_p0      <= '0;
      sel_p0      <= '0;
      wait_p0     <= '0;
      pass_p0     <= 1'b0;
      fail_idx_p0 <= '0;
      pass_cnt_p0 <= '0;
      fail_cnt_p0 <= '0;
    end else begin
      state_p0    <= state_nxt;
      vec_p0      <= vec_nxt;
      sel_p0      <= sel_nxt;
      wait_p0     <= wait_nxt;
      pass_p0     <= pass_nxt;
      fail_idx_p0 <= fail_idx_nxt;
      pass_cnt_p0 <= pass_cnt_nxt;
      fail_cnt_p0 <= fail_cnt_nxt;
    end
  end

  assign cand_ready   = (state_p0 == ST_IDLE);
  assign res_valid    = (state_p0 == ST_RESULT);
  assign busy         = (state_p0 != ST_IDLE);
  assign eval_vec     = vec_p0;
  assign split_sel    = sel_p0;
  assign res_pass     = pass_p0;
  assign res_fail_idx = fail_idx_p0;
  assign pass_cnt     = pass_cnt_p0;
  assign fail_cnt     = fail_cnt_p0;

endmodule

// File: tb/tb_split_scheduler.sv
// Bench for split_scheduler: two instances (EVAL_LAT 1 and 3) driven with
// random candidates and split patterns, checked against a pattern-level model.
module tb_split_scheduler;

  localparam int NS = 8;

  logic        clk;
  logic        rst;
  logic        cand_valid   [2];
  logic        cand_ready   [2];
  logic [63:0] cand_data    [2];
  logic [63:0] eval_vec     [2];
  logic [2:0]  split_sel    [2];
  logic        split_x      [2];
  logic        abort        [2];
  logic        res_valid    [2];
  logic        res_ready    [2];
  logic        res_pass     [2];
  logic [2:0]  res_fail_idx [2];
  logic        busy         [2];
  logic [15:0] pass_cnt     [2];
  logic [15:0] fail_cnt     [2];

  logic [15:0] exp_pass [2];
  logic [15:0] exp_fail [2];
  int n_checks;
  int n_fail;

  split_scheduler #(.NUM_SPLITS(NS), .CAND_W(64), .EVAL_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .cand_valid(cand_valid[0]), .cand_ready(cand_ready[0]), .cand_data(cand_data[0]),
    .eval_vec(eval_vec[0]), .split_sel(split_sel[0]), .split_x(split_x[0]),
    .abort(abort[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_pass(res_pass[0]), .res_fail_idx(res_fail_idx[0]), .busy(busy[0]),
    .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0])
  );

  split_scheduler #(.NUM_SPLITS(NS), .CAND_W(64), .EVAL_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .cand_valid(cand_valid[1]), .cand_ready(cand_ready[1]), .cand_data(cand_data[1]),
    .eval_vec(eval_vec[1]), .split_sel(split_sel[1]), .split_x(split_x[1]),
    .abort(abort[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_pass(res_pass[1]), .res_fail_idx(res_fail_idx[1]), .busy(busy[1]),
    .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_model(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  task automatic check_reset_values();
    for (int v = 0; v < 2; v++) begin
      check_eq("rst_cand_ready", 64'(cand_ready[v]), 64'd1);
      check_eq("rst_res_valid", 64'(res_valid[v]), 64'd0);
      check_eq("rst_busy", 64'(busy[v]), 64'd0);
      check_eq("rst_res_pass", 64'(res_pass[v]), 64'd0);
      check_eq("rst_fail_idx", 64'(res_fail_idx[v]), 64'd0);
      check_eq("rst_split_sel", 64'(split_sel[v]), 64'd0);
      check_eq("rst_eval_vec", eval_vec[v], 64'd0);
      check_eq("rst_pass_cnt", 64'(pass_cnt[v]), 64'd0);
      check_eq("rst_fail_cnt", 64'(fail_cnt[v]), 64'd0);
    end
  endtask

  // One candidate: pat[i]=1 means split i is satisfied. abort_at<0 means no abort.
  task automatic run(input int u, input logic [63:0] data, input logic [7:0] pat,
                     input bit glitch, input int abort_at, input int hold);
    int  lat;
    int  k;
    int  len;
    int  idx;
    bit  ok;
    lat = (u == 0) ? 1 : 3;
    k = NS;
    for (int i = NS - 1; i >= 0; i--) if (!pat[i]) k = i;
    ok  = (k == NS);
    len = ok ? NS * lat : (k + 1) * lat;

    check_eq("cand_ready_idle", 64'(cand_ready[u]), 64'd1);
    cand_valid[u] = 1'b1;
    cand_data[u]  = data;
    split_x[u]    = 1'b0;
    abort[u]      = 1'($urandom % 2);   // abort in IDLE must not block acceptance
    @(posedge clk); #1;
    abort[u] = 1'b0;
    check_eq("busy_after_accept", 64'(busy[u]), 64'd1);
    check_eq("eval_vec_latched", eval_vec[u], data);

    for (int t = 1; t <= len; t++) begin
      idx = (t - 1) / lat;
      cand_valid[u] = 1'($urandom % 2);
      cand_data[u]  = {$urandom, $urandom};
      check_eq("split_sel_walk", 64'(split_sel[u]), 64'(idx));
      check_eq("res_valid_low_eval", 64'(res_valid[u]), 64'd0);
      check_eq("eval_vec_hold", eval_vec[u], data);
      if (idx == abort_at && ((t - 1) % lat) == 0) begin
        cand_valid[u] = 1'b0;
        abort[u]      = 1'b1;
        split_x[u]    = pat[idx];
        @(posedge clk); #1;
        abort[u] = 1'b0;
        check_eq("abort_busy", 64'(busy[u]), 64'd0);
        check_eq("abort_res_valid", 64'(res_valid[u]), 64'd0);
        check_eq("abort_cand_ready", 64'(cand_ready[u]), 64'd1);
        check_eq("abort_pass_cnt", 64'(pass_cnt[u]), 64'(exp_pass[u]));
        check_eq("abort_fail_cnt", 64'(fail_cnt[u]), 64'(exp_fail[u]));
        check_eq("abort_eval_vec", eval_vec[u], data);
        return;
      end
      if ((t % lat) == 0) split_x[u] = pat[idx];
      else                split_x[u] = glitch ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end

    cand_valid[u] = 1'b0;
    split_x[u]    = 1'($urandom % 2);
    if (ok) exp_pass[u] = sat_model(exp_pass[u]);
    else    exp_fail[u] = sat_model(exp_fail[u]);
    check_eq("res_valid_at_latency", 64'(res_valid[u]), 64'd1);
    check_eq("res_cand_ready", 64'(cand_ready[u]), 64'd0);
    check_eq("res_busy", 64'(busy[u]), 64'd1);
    check_eq("res_pass", 64'(res_pass[u]), 64'(ok));
    check_eq("res_fail_idx", 64'(res_fail_idx[u]), ok ? 64'd0 : 64'(k));
    check_eq("res_pass_cnt", 64'(pass_cnt[u]), 64'(exp_pass[u]));
    check_eq("res_fail_cnt", 64'(fail_cnt[u]), 64'(exp_fail[u]));
    check_eq("sel_bound", 64'(int'(split_sel[u]) <= (ok ? NS - 1 : k)), 64'd1);

    for (int h = 0; h < hold; h++) begin
      res_ready[u]  = 1'b0;
      cand_valid[u] = 1'b1;
      abort[u]      = 1'($urandom % 2);
      split_x[u]    = 1'($urandom % 2);
      @(posedge clk); #1;
      check_eq("hold_res_valid", 64'(res_valid[u]), 64'd1);
      check_eq("hold_res_pass", 64'(res_pass[u]), 64'(ok));
      check_eq("hold_fail_idx", 64'(res_fail_idx[u]), ok ? 64'd0 : 64'(k));
      check_eq("hold_cand_ready", 64'(cand_ready[u]), 64'd0);
      check_eq("hold_pass_cnt", 64'(pass_cnt[u]), 64'(exp_pass[u]));
      check_eq("hold_fail_cnt", 64'(fail_cnt[u]), 64'(exp_fail[u]));
    end

    abort[u]      = 1'b0;
    res_ready[u]  = 1'b1;
    cand_valid[u] = 1'b1;   // must not be taken in the handshake cycle
    @(posedge clk); #1;
    res_ready[u]  = 1'b0;
    cand_valid[u] = 1'b0;
    check_eq("handshake_res_valid", 64'(res_valid[u]), 64'd0);
    check_eq("handshake_busy", 64'(busy[u]), 64'd0);
    check_eq("handshake_cand_ready", 64'(cand_ready[u]), 64'd1);
  endtask

  // Start a passing run, then assert reset asynchronously after 'cycles' edges.
  task automatic reset_mid(input int u, input int cycles, input bit expect_result);
    cand_valid[u] = 1'b1;
    cand_data[u]  = {$urandom, $urandom};
    split_x[u]    = 1'b1;
    @(posedge clk); #1;
    cand_valid[u] = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    check_eq("pre_rst_res_valid", 64'(res_valid[u]), 64'(expect_result));
    check_eq("pre_rst_busy", 64'(busy[u]), 64'd1);
    rst = 1'b1;
    #1;
    exp_pass[0] = '0; exp_fail[0] = '0;
    exp_pass[1] = '0; exp_fail[1] = '0;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] pat;
    int         ab;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    for (int v = 0; v < 2; v++) begin
      cand_valid[v] = 1'b0;
      cand_data[v]  = '0;
      split_x[v]    = 1'b0;
      abort[v]      = 1'b0;
      res_ready[v]  = 1'b0;
      exp_pass[v]   = '0;
      exp_fail[v]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run(0, 64'h1234, 8'hFF, 1'b0, -1, 0);          // all pass, latency 8
    run(0, 64'hABCD, 8'hDF, 1'b0, -1, 0);          // fails at split 5, latency 6
    run(1, 64'h5555, 8'hFF, 1'b1, -1, 1);          // latency 24 with glitching x
    run(0, 64'h7777, 8'hF7, 1'b0, -1, 10);         // result held 10 cycles
    run(0, 64'h9999, 8'hFF, 1'b0, 3, 0);           // abort at split 3
    run(1, 64'h8888, 8'hFF, 1'b1, 3, 0);
    run(1, 64'h4444, 8'hFE, 1'b1, -1, 2);          // fail at split 0

    // Randomized candidates and split patterns.
    for (int r = 0; r < 40; r++) begin
      pat = ($urandom % 2) ? 8'hFF : 8'($urandom);
      ab  = (($urandom % 4) == 0) ? int'($urandom % NS) : -1;
      run(int'($urandom % 2), {$urandom, $urandom}, pat, 1'($urandom % 2), ab, int'($urandom % 4));
    end

    // Counter saturation: preload near the top, then run past it.
    force u_dut0.pass_cnt_p0 = 16'hFFFC;
    @(posedge clk); #1;
    release u_dut0.pass_cnt_p0;
    exp_pass[0] = 16'hFFFC;
    check_eq("preload_pass_cnt", 64'(pass_cnt[0]), 64'h0FFFC);
    for (int r = 0; r < 4; r++) run(0, {$urandom, $urandom}, 8'hFF, 1'b0, -1, 0);
    check_eq("pass_cnt_saturated", 64'(pass_cnt[0]), 64'h0FFFF);
    force u_dut0.fail_cnt_p0 = 16'hFFFE;
    @(posedge clk); #1;
    release u_dut0.fail_cnt_p0;
    exp_fail[0] = 16'hFFFE;
    for (int r = 0; r < 3; r++) run(0, {$urandom, $urandom}, 8'h7F, 1'b0, -1, 0);
    check_eq("fail_cnt_saturated", 64'(fail_cnt[0]), 64'h0FFFF);

    // Asynchronous reset mid-EVAL and mid-RESULT.
    reset_mid(0, 3, 1'b0);
    reset_mid(1, 9, 1'b0);
    reset_mid(0, 10, 1'b1);
    run(0, 64'h1234, 8'hFF, 1'b0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
